// File: rtl/digit_scan_scheduler_if.sv
// Display-side bundle of the digit scan scheduler: clock datapath digits and
// blink requests in, digit enables, segments and frame pulse out.
interface digit_scan_scheduler_if;
  logic        enable_i;
  logic [31:0] digits_i;
  logic        blink_sec_i;
  logic        blink_min_i;
  logic        blink_hr_i;
  logic [7:0]  digit_sel_o;
  logic [6:0]  seg_o;
  logic        frame_done_o;

  // master: the clock datapath side; slave: the scheduler itself
  modport master (
    output enable_i, digits_i, blink_sec_i, blink_min_i, blink_hr_i,
    input  digit_sel_o, seg_o, frame_done_o
  );

  modport slave (
    input  enable_i, digits_i, blink_sec_i, blink_min_i, blink_hr_i,
    output digit_sel_o, seg_o, frame_done_o
  );
endinterface

// File: rtl/digit_scan_scheduler.sv
// Scans eight BCD digits onto one seven-segment bus with a per-frame snapshot
// and field blinking. Optional macro LEADING_ZERO_BLANK_EN blanks a zero decahr.
module digit_scan_scheduler #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 25
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  digit_scan_scheduler_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_slot;
  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_phase;
  logic [31:0]   r_snap;
  logic          r_en_d;
  logic          r_blink_d;
  logic [7:0]    r_digit_sel;
  logic [6:0]    r_seg;
  logic          r_frame_done;

  logic          w_tick;
  logic          w_frame_end;
  logic          w_en_rise;
  logic          w_blink_any;
  logic          w_blink_rise;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic          w_field_blink;
  logic          w_blank;

  assign w_tick       = (r_presc == PRESC_MAX);
  assign w_frame_end  = w_tick && (r_slot == 3'd7);
  assign w_en_rise    = bus.enable_i && !r_en_d;
  assign w_blink_any  = bus.blink_sec_i | bus.blink_min_i | bus.blink_hr_i;
  assign w_blink_rise = w_blink_any && !r_blink_d;
  assign w_nib        = r_snap[{r_slot, 2'b00} +: 4];

  always_comb begin
    w_seg = 7'b1000000;
    case (w_nib)
      4'd0: w_seg = 7'b0111111;
      4'd1: w_seg = 7'b0000110;
      4'd2: w_seg = 7'b1011011;
      4'd3: w_seg = 7'b1001111;
      4'd4: w_seg = 7'b1100110;
      4'd5: w_seg = 7'b1101101;
      4'd6: w_seg = 7'b1111101;
      4'd7: w_seg = 7'b0000111;
      4'd8: w_seg = 7'b1111111;
      4'd9: w_seg = 7'b1101111;
      default: w_seg = 7'b1000000;
    endcase
  end

  // Slot pairs map to fields: 2-3 sec, 4-5 min, 6-7 hr; 0-1 never blink.
  always_comb begin
    w_field_blink = 1'b0;
    case (r_slot[2:1])
      2'd1:    w_field_blink = bus.blink_sec_i;
      2'd2:    w_field_blink = bus.blink_min_i;
      2'd3:    w_field_blink = bus.blink_hr_i;
      default: w_field_blink = 1'b0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank = (w_field_blink && r_blink_phase) ||
                   ((r_slot == 3'd7) && (w_nib == 4'd0));
`else
  assign w_blank = w_field_blink && r_blink_phase;
`endif

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_presc       <= '0;
      r_slot        <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_snap        <= '0;
      r_en_d        <= 1'b0;
      r_blink_d     <= 1'b0;
      r_digit_sel   <= '0;
      r_seg         <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_en_d    <= bus.enable_i;
      r_blink_d <= w_blink_any;
      if (!bus.enable_i) begin
        r_presc      <= '0;
        r_slot       <= '0;
        r_frame_cnt  <= '0;
        r_digit_sel  <= '0;
        r_seg        <= '0;
        r_frame_done <= 1'b0;
      end else begin
        r_presc      <= w_tick ? '0 : r_presc + 1'b1;
        r_frame_done <= w_frame_end;
        if (w_tick) begin
          r_slot <= r_slot + 3'd1;
        end
        // Reloading only at frame boundaries keeps every frame tear-free.
        if (w_frame_end || w_en_rise) begin
          r_snap <= bus.digits_i;
        end
        // A fresh blink request restarts the blink cycle in the visible half.
        if (w_blink_rise) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= 1'b0;
        end else if (w_frame_end) begin
          if (r_frame_cnt == FRAME_MAX) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
          end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end
        r_digit_sel <= 8'd1 << r_slot;
        r_seg       <= w_blank ? 7'd0 : w_seg;
      end
    end
  end

  assign bus.digit_sel_o  = r_digit_sel;
  assign bus.seg_o        = r_seg;
  assign bus.frame_done_o = r_frame_done;

endmodule

// File: tb/tb_digit_scan_scheduler.sv
// Directed bench for digit_scan_scheduler with SCAN_DIV=4, BLINK_DIV=2; every
// slot is sampled mid-slot on the falling edge, frames aligned to frame_done_o.
module tb_digit_scan_scheduler;

  logic clk;
  logic nreset;
  int   n_checks;
  int   n_pass;

  digit_scan_scheduler_if bus ();

  digit_scan_scheduler #(
    .SCAN_DIV  (4),
    .BLINK_DIV (2)
  ) dut (
    .clk_i    (clk),
    .nreset_i (nreset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int slot, input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h40;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 7 && nib == 4'd0) s = 7'h00;
`endif
    return s;
  endfunction

  task automatic test_reset();
    nreset = 1'b0;
    bus.enable_i = 1'b0;
    bus.digits_i = 32'h0;
    bus.blink_sec_i = 1'b0;
    bus.blink_min_i = 1'b0;
    bus.blink_hr_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.digit_sel_o, bus.seg_o, bus.frame_done_o} !== 16'h0)
      $display("FAIL reset_outputs: got sel=%h seg=%b fd=%b, want all 0",
               bus.digit_sel_o, bus.seg_o, bus.frame_done_o);
    else n_pass++;
    nreset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.digit_sel_o, bus.seg_o, bus.frame_done_o} !== 16'h0)
      $display("FAIL reset_disabled: got sel=%h seg=%b fd=%b, want all 0",
               bus.digit_sel_o, bus.seg_o, bus.frame_done_o);
    else n_pass++;
    bus.digits_i = 32'h1234_5678;
    bus.enable_i = 1'b1;
  endtask

  task automatic test_scan();
    logic [31:0] d;
    logic [7:0]  es;
    logic [6:0]  eg;
    int          pulses;
    d = 32'h1234_5678;
    for (int n = 0; n < 8; n++) begin
      repeat (3) @(negedge clk);
      es = 8'd1 << n;
      eg = exp_seg(n, d[n*4 +: 4]);
      n_checks++;
      if ({bus.digit_sel_o, bus.seg_o, bus.frame_done_o} !== {es, eg, 1'b0})
        $display("FAIL scan slot %0d: got sel=%h seg=%b fd=%b, want sel=%h seg=%b fd=0",
                 n, bus.digit_sel_o, bus.seg_o, bus.frame_done_o, es, eg);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.frame_done_o !== 1'b1)
      $display("FAIL scan_frame_done: got %b, want 1", bus.frame_done_o);
    else n_pass++;
    pulses = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (bus.frame_done_o === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1 || bus.frame_done_o !== 1'b1)
      $display("FAIL scan_frame_period: got %0d pulses (last fd=%b), want 1 pulse at cycle 32",
               pulses, bus.frame_done_o);
    else n_pass++;
  endtask

  task automatic test_tear_free();
    logic [31:0] d;
    logic [7:0]  es;
    logic [6:0]  eg;
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? 32'h1234_5678 : 32'h0000_0009;
      for (int n = 0; n < 8; n++) begin
        repeat (3) @(negedge clk);
        es = 8'd1 << n;
        eg = exp_seg(n, d[n*4 +: 4]);
        n_checks++;
        if ({bus.digit_sel_o, bus.seg_o} !== {es, eg})
          $display("FAIL tear frame %0d slot %0d: got sel=%h seg=%b, want sel=%h seg=%b",
                   f, n, bus.digit_sel_o, bus.seg_o, es, eg);
        else n_pass++;
        if (f == 0 && n == 3) bus.digits_i = 32'h0000_0009;
        if (f == 1 && n == 0) bus.digits_i = 32'h8765_4321;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_blink_sec();
    logic [31:0] d;
    logic [7:0]  es;
    logic [6:0]  eg;
    d = 32'h8765_4321;
    bus.blink_sec_i = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int n = 0; n < 8; n++) begin
        repeat (3) @(negedge clk);
        es = 8'd1 << n;
        eg = ((f == 2 || f == 3) && (n == 2 || n == 3)) ? 7'h00 : exp_seg(n, d[n*4 +: 4]);
        n_checks++;
        if ({bus.digit_sel_o, bus.seg_o} !== {es, eg})
          $display("FAIL blink_sec frame %0d slot %0d: got sel=%h seg=%b, want sel=%h seg=%b",
                   f, n, bus.digit_sel_o, bus.seg_o, es, eg);
        else n_pass++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_blink_restart();
    logic [31:0] d;
    logic [7:0]  es;
    logic [6:0]  eg;
    d = 32'h8765_4321;
    for (int f = 0; f < 5; f++) begin
      for (int n = 0; n < 8; n++) begin
        repeat (3) @(negedge clk);
        es = 8'd1 << n;
        eg = ((f == 1 && (n == 2 || n == 3)) || (f == 4 && n == 6)) ?
             7'h00 : exp_seg(n, d[n*4 +: 4]);
        n_checks++;
        if ({bus.digit_sel_o, bus.seg_o} !== {es, eg})
          $display("FAIL blink_restart frame %0d slot %0d: got sel=%h seg=%b, want sel=%h seg=%b",
                   f, n, bus.digit_sel_o, bus.seg_o, es, eg);
        else n_pass++;
        if (f == 1 && n == 7) bus.blink_sec_i = 1'b0;
        if (f == 4 && n == 6) bus.blink_hr_i = 1'b0;
        @(negedge clk);
        if (f == 1 && n == 7) bus.blink_hr_i = 1'b1;
        if (f == 4 && n == 6) begin
          n_checks++;
          if (bus.seg_o !== 7'h07)
            $display("FAIL blink_release: got seg=%b, want seg=%b", bus.seg_o, 7'h07);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [31:0] d;
    logic [7:0]  es;
    logic [6:0]  eg;
    d = 32'h8765_4321;
    for (int n = 0; n < 6; n++) begin
      repeat (3) @(negedge clk);
      es = 8'd1 << n;
      eg = exp_seg(n, d[n*4 +: 4]);
      n_checks++;
      if ({bus.digit_sel_o, bus.seg_o} !== {es, eg})
        $display("FAIL enable_pre slot %0d: got sel=%h seg=%b, want sel=%h seg=%b",
                 n, bus.digit_sel_o, bus.seg_o, es, eg);
      else n_pass++;
      if (n < 5) @(negedge clk);
    end
    bus.enable_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.digit_sel_o, bus.seg_o, bus.frame_done_o} !== 16'h0)
      $display("FAIL enable_off: got sel=%h seg=%b fd=%b, want all 0",
               bus.digit_sel_o, bus.seg_o, bus.frame_done_o);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.digit_sel_o, bus.seg_o} !== 15'h0)
      $display("FAIL enable_off_hold: got sel=%h seg=%b, want 0",
               bus.digit_sel_o, bus.seg_o);
    else n_pass++;
    d = 32'h0123_4B98;
    bus.digits_i = d;
    bus.enable_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      repeat (3) @(negedge clk);
      es = 8'd1 << n;
      eg = exp_seg(n, d[n*4 +: 4]);
      n_checks++;
      if ({bus.digit_sel_o, bus.seg_o} !== {es, eg})
        $display("FAIL enable_resume slot %0d: got sel=%h seg=%b, want sel=%h seg=%b",
                 n, bus.digit_sel_o, bus.seg_o, es, eg);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (bus.frame_done_o !== 1'b1)
      $display("FAIL enable_resume_frame_done: got %b, want 1", bus.frame_done_o);
    else n_pass++;
  endtask

  task automatic test_invalid_digit();
    logic [6:0] e7;
    repeat (11) @(negedge clk);
    n_checks++;
    if ({bus.digit_sel_o, bus.seg_o} !== {8'h04, 7'h40})
      $display("FAIL invalid_dash: got sel=%h seg=%b, want sel=04 seg=1000000",
               bus.digit_sel_o, bus.seg_o);
    else n_pass++;
    repeat (20) @(negedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    e7 = 7'h00;
`else
    e7 = 7'h3F;
`endif
    n_checks++;
    if ({bus.digit_sel_o, bus.seg_o} !== {8'h80, e7})
      $display("FAIL decahr_zero: got sel=%h seg=%b, want sel=80 seg=%b",
               bus.digit_sel_o, bus.seg_o, e7);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    repeat (6) @(negedge clk);
    n_checks++;
    if ({bus.digit_sel_o, bus.seg_o} !== {8'h02, 7'h6F})
      $display("FAIL reset_mid_pre: got sel=%h seg=%b, want sel=02 seg=1101111",
               bus.digit_sel_o, bus.seg_o);
    else n_pass++;
    #2;
    nreset = 1'b0;
    #1;
    n_checks++;
    if ({bus.digit_sel_o, bus.seg_o, bus.frame_done_o} !== 16'h0)
      $display("FAIL reset_mid: got sel=%h seg=%b fd=%b, want all 0",
               bus.digit_sel_o, bus.seg_o, bus.frame_done_o);
    else n_pass++;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_scan();
    test_tear_free();
    test_blink_sec();
    test_blink_restart();
    test_enable();
    test_invalid_digit();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
